// File: rtl/start_launcher.sv
// Push-button launcher: synchronizes and debounces btn, issues one start pulse per press,
// then holds off until a fresh done rising edge or a timeout, tracking launches and timeout errors.
module start_launcher #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 64,
   parameter int CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rstAL,
   input  logic       btn,
   input  logic       done,
   input  logic       clr_err,
   output logic       start,
   output logic       busy,
   output logic       timeout_err,
   output logic [7:0] launch_count
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DEBOUNCE  = 3'd1,
      S_FIRE      = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_RELEASE   = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] DC_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             done_prev_q, done_prev_d;
   logic [CNT_W-1:0] dcnt_q, dcnt_d;
   logic [CNT_W-1:0] tcnt_q, tcnt_d;
   logic             timeout_err_q, timeout_err_d;
   logic [7:0]       launch_count_q, launch_count_d;
   logic             btn_s, done_rise, timeout_set;

   assign btn_s     = sync2_q;
   // A done level left high from the previous launch never counts; only a fresh 0->1 does.
   assign done_rise = done & ~done_prev_q;

   always_comb begin
      sync1_d        = btn;
      sync2_d        = sync1_q;
      done_prev_d    = done;
      state_d        = state_q;
      dcnt_d         = dcnt_q;
      tcnt_d         = tcnt_q;
      launch_count_d = launch_count_q;
      timeout_set    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (btn_s) begin
               state_d = S_DEBOUNCE;
               dcnt_d  = '0;
            end
         end
         S_DEBOUNCE: begin
            if (!btn_s)                state_d = S_IDLE;
            else if (dcnt_q == DC_LAST) state_d = S_FIRE;
            else                       dcnt_d  = dcnt_q + CNT_W'(1);
         end
         S_FIRE: begin
            launch_count_d = launch_count_q + 8'd1;
            state_d        = S_WAIT_DONE;
            tcnt_d         = '0;
         end
         S_WAIT_DONE: begin
            // done_rise has priority over a coincident timeout expiry
            if (done_rise) begin
               state_d = S_RELEASE;
            end else if (tcnt_q == TC_LAST) begin
               timeout_set = 1'b1;
               state_d     = S_RELEASE;
            end else begin
               tcnt_d = tcnt_q + CNT_W'(1);
            end
         end
         S_RELEASE: begin
            if (!btn_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (timeout_set)  timeout_err_d = 1'b1;
      else if (clr_err) timeout_err_d = 1'b0;
      else              timeout_err_d = timeout_err_q;
   end

   always_ff @(posedge clk or negedge rstAL) begin
      if (!rstAL) begin
         state_q        <= S_IDLE;
         sync1_q        <= 1'b0;
         sync2_q        <= 1'b0;
         done_prev_q    <= 1'b0;
         dcnt_q         <= '0;
         tcnt_q         <= '0;
         timeout_err_q  <= 1'b0;
         launch_count_q <= 8'd0;
      end else begin
         state_q        <= state_d;
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         done_prev_q    <= done_prev_d;
         dcnt_q         <= dcnt_d;
         tcnt_q         <= tcnt_d;
         timeout_err_q  <= timeout_err_d;
         launch_count_q <= launch_count_d;
      end
   end

   assign start        = (state_q == S_FIRE);
   assign busy         = (state_q == S_FIRE) || (state_q == S_WAIT_DONE);
   assign timeout_err  = timeout_err_q;
   assign launch_count = launch_count_q;

endmodule

// File: tb/tb_start_launcher.sv
// Randomized self-checking bench for start_launcher against a run-length/age based reference model.
`timescale 1ns/1ps
module tb_start_launcher;

   localparam int D = 4;
   localparam int T = 64;

   logic       clk = 1'b0;
   logic       rstAL, btn, done, clr_err;
   logic       start, busy, timeout_err;
   logic [7:0] launch_count;

   start_launcher #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
      .clk(clk), .rstAL(rstAL), .btn(btn), .done(done), .clr_err(clr_err),
      .start(start), .busy(busy), .timeout_err(timeout_err), .launch_count(launch_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;

   // reference model: m_age = -1 idle/armed/holding, 0 launch cycle, k>=1 k-th waiting cycle
   int m_run, m_age, m_cnt;
   bit m_hold, m_err, m_s1, m_s2, m_dp;

   // stimulus controls and observation counters
   int cyc = 0, since = -1, ds_mode = 0, ds_n = 13;
   bit f = 0, btn_cmd = 0, clr_cmd = 0, clr_at_to = 0;
   int n_start, n_busy, first_start;

   task automatic chk(input string tag, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic m_reset();
      m_run = 0; m_age = -1; m_cnt = 0; m_hold = 0; m_err = 0;
      m_s1 = 0; m_s2 = 0; m_dp = 0; since = -1;
   endtask

   // advances the model across one rising edge using the inputs of the current cycle
   task automatic model_step();
      bit bs, rise, set;
      bs = m_s2; rise = done && !m_dp; set = 0;
      if (m_age == 0) begin
         m_cnt = (m_cnt + 1) % 256;
         m_age = 1;
      end else if (m_age > 0) begin
         if (rise) begin m_age = -1; m_hold = 1; end
         else if (m_age == T) begin set = 1; m_age = -1; m_hold = 1; end
         else m_age++;
      end else if (m_hold) begin
         if (!bs) m_hold = 0;
      end else if (bs) begin
         m_run++;
         if (m_run == D + 1) begin m_age = 0; m_run = 0; end
      end else begin
         m_run = 0;
      end
      if (set) m_err = 1;
      else if (clr_err) m_err = 0;
      m_dp = done; m_s2 = m_s1; m_s1 = btn;
   endtask

   task automatic clr_obs();
      n_start = 0; n_busy = 0; first_start = -1;
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      chk("start", int'(start), int'(m_age == 0));
      chk("busy", int'(busy), int'(m_age >= 0));
      chk("timeout_err", int'(timeout_err), int'(m_err));
      chk("launch_count", int'(launch_count), m_cnt);
      if (start) begin n_start++; if (first_start < 0) first_start = cyc; end
      if (busy) n_busy++;
      if (m_age == 0) since = 0;
      else if (since >= 0) since++;
      case (ds_mode)
         0: f = 0;
         1: begin
            if (since == 1) f = 0;
            if (since == ds_n) f = 1;
         end
         default: f = 1'($urandom_range(0, 1));
      endcase
      done = f;
      clr_err = clr_cmd | (clr_at_to & (m_age == T));
      btn = btn_cmd;
      model_step();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // called right after tick(): reset lands before the coming edge, which the model then replays
   task automatic sync_reset();
      #2 rstAL = 0;
      m_reset();
      #1 rstAL = 1;
      model_step();
      clr_obs();
   endtask

   task automatic press(input int hold, input int rel);
      btn_cmd = 1; ticks(hold);
      btn_cmd = 0; ticks(rel);
   endtask

   int c0;

   initial begin
      rstAL = 0; btn = 0; done = 0; clr_err = 0;
      m_reset(); clr_obs();
      #17 rstAL = 1;

      // reset state then a held press with downstream done 13 cycles after start
      ds_mode = 1; ds_n = 13;
      ticks(2);
      btn_cmd = 1; tick(); c0 = cyc;
      ticks(29);
      chk("t1_starts", n_start, 1);
      chk("t1_latency", first_start - c0, 7);
      chk("t1_busy_len", n_busy, 14);
      chk("t1_count", int'(launch_count), 1);
      btn_cmd = 0; ticks(5);

      // bounce rejection
      sync_reset();
      btn_cmd = 1; tick(); btn_cmd = 0; tick(); btn_cmd = 1; ticks(2); btn_cmd = 0; ticks(12);
      chk("t2_starts", n_start, 0);
      chk("t2_count", int'(launch_count), 0);

      // timeout, clear, set-vs-clear collision, done-vs-timeout collision
      sync_reset();
      ds_mode = 0;
      press(80, 4);
      chk("t3_busy_len", n_busy, 65);
      chk("t3_err", int'(timeout_err), 1);
      clr_cmd = 1; tick(); clr_cmd = 0; tick();
      chk("t3_clr", int'(timeout_err), 0);
      clr_at_to = 1; press(80, 4); clr_at_to = 0;
      chk("t3_set_wins", int'(timeout_err), 1);
      clr_cmd = 1; tick(); clr_cmd = 0; tick();
      clr_obs();
      ds_mode = 1; ds_n = T;
      press(80, 4);
      chk("t3_done_wins_busy", n_busy, 65);
      chk("t3_done_wins_err", int'(timeout_err), 0);

      // stale done held high before the press
      sync_reset();
      ds_mode = 1; ds_n = 20; f = 1;
      ticks(3);
      press(30, 4);
      chk("t4_busy_len", n_busy, 21);
      chk("t4_err", int'(timeout_err), 0);

      // 256 launches wrap the count
      sync_reset();
      ds_mode = 1; ds_n = 3;
      for (int i = 0; i < 256; i++) press(12, 4);
      chk("t5_starts", n_start, 256);
      chk("t5_wrap", int'(launch_count), 0);

      // asynchronous reset in the middle of a wait with a sticky error set
      sync_reset();
      ds_mode = 0;
      press(80, 4);
      btn_cmd = 1; ticks(12);
      chk("t6_in_wait", int'(busy), 1);
      @(posedge clk); #3 rstAL = 0;
      #0.5;
      chk("t6_rst_start", int'(start), 0);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_err", int'(timeout_err), 0);
      chk("t6_rst_count", int'(launch_count), 0);
      #0.5 rstAL = 1;
      m_reset(); clr_obs();
      btn_cmd = 0; ticks(4);
      ds_mode = 1; ds_n = 5;
      press(15, 4);
      chk("t6_relaunch", n_start, 1);
      chk("t6_count", int'(launch_count), 1);

      // random btn, done and clr_err
      ds_mode = 2;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 7) == 0) btn_cmd = ~btn_cmd;
         clr_cmd = ($urandom_range(0, 19) == 0);
         tick();
      end
      clr_cmd = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
